// File: rtl/exc_ctrl_pkg.sv
// Shared types for the exception sequencer: cause codes, per-stage slot payload, FSM states.
package exc_ctrl_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned CODE_W = 5;
  localparam logic [PC_W-1:0] HANDLER_PC_DEF = 32'h0000_4180;

  typedef enum logic [CODE_W-1:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_t;

  // Code 0 on a slot doubles as "no exception recorded".
  localparam exc_code_t EXC_NONE = EXC_INT;

  typedef struct packed {
    exc_code_t       code;
    logic            bd;
    logic [PC_W-1:0] pc;
  } slot_t;

  localparam slot_t SLOT_CLR = '{code: EXC_NONE, bd: 1'b0, pc: 32'h0};

  typedef enum logic {ST_RUN, ST_HANDLER} state_t;

  function automatic exc_code_t f_code(input logic adel);
    return adel ? EXC_ADEL : EXC_NONE;
  endfunction

  function automatic exc_code_t d_code(input logic ri, input logic sys);
    if (ri)  return EXC_RI;
    if (sys) return EXC_SYS;
    return EXC_NONE;
  endfunction

  function automatic exc_code_t e_code(input logic ov, input logic ovl, input logic ovs);
    if (ov)  return EXC_OV;
    if (ovl) return EXC_ADEL;
    if (ovs) return EXC_ADES;
    return EXC_NONE;
  endfunction

  function automatic exc_code_t m_code(input logic adel, input logic ades);
    if (adel) return EXC_ADEL;
    if (ades) return EXC_ADES;
    return EXC_NONE;
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Pipeline/CP0-facing signal bundle of the exception sequencer.
interface exc_ctrl_if #(parameter int unsigned CNT_W = 16);
  logic [31:0]      pc_f;
  logic             bd_f;
  logic             adel_f;
  logic             ri_d;
  logic             syscall_d;
  logic             ov_e;
  logic             ovl_e;
  logic             ovs_e;
  logic             adel_m;
  logic             ades_m;
  logic             eret_m;
  logic             stall;
  logic             req;
  logic [31:0]      epc;
  logic [4:0]       exc_code_m;
  logic             bd_m;
  logic [31:0]      vpc_m;
  logic             exl_clr;
  logic             flush;
  logic             kill_m;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] exc_cnt;
  logic [CNT_W-1:0] int_cnt;
  logic             in_handler;

  modport master (
    output pc_f, bd_f, adel_f, ri_d, syscall_d, ov_e, ovl_e, ovs_e,
           adel_m, ades_m, eret_m, stall, req, epc,
    input  exc_code_m, bd_m, vpc_m, exl_clr, flush, kill_m, redirect,
           redirect_pc, exc_cnt, int_cnt, in_handler
  );

  modport slave (
    input  pc_f, bd_f, adel_f, ri_d, syscall_d, ov_e, ovl_e, ovs_e,
           adel_m, ades_m, eret_m, stall, req, epc,
    output exc_code_m, bd_m, vpc_m, exl_clr, flush, kill_m, redirect,
           redirect_pc, exc_cnt, int_cnt, in_handler
  );
endinterface

// File: rtl/exc_slot.sv
// One pipeline-stage exception slot: keeps the earliest code, supports hold and bubble insertion.
module exc_slot
  import exc_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  input  logic      hold,
  input  logic      bubble,
  input  slot_t     prev,
  input  exc_code_t stage_code,
  output slot_t     q
);

  slot_t q_n;

  // Flush beats hold/bubble; an already-recorded code masks this stage's detection.
  always_comb begin
    q_n = q;
    if (flush) begin
      q_n = SLOT_CLR;
    end else if (hold) begin
      q_n = q;
    end else if (bubble) begin
      q_n = '{code: EXC_NONE, bd: prev.bd, pc: prev.pc};
    end else begin
      q_n = prev;
      if (prev.code == EXC_NONE) q_n.code = stage_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q <= SLOT_CLR;
    else       q <= q_n;
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: per-stage code tracking, CP0 presentation, flush/redirect and entry statistics.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
  parameter int unsigned CNT_W      = 16
)(
  input  logic clk,
  input  logic reset,
  exc_ctrl_if.slave bus
);

  slot_t      f_in, d_q, e_q, m_q;
  exc_code_t  code_m;
  state_t     state, state_n;
  logic       flush_c, kill_c, redir_c, exl_clr_c;
  logic [31:0] redir_pc_c;
  logic [CNT_W-1:0] exc_cnt, int_cnt;

  always_comb f_in = '{code: EXC_NONE, bd: bus.bd_f, pc: bus.pc_f};

  exc_slot u_slot_d (
    .clk(clk), .reset(reset), .flush(flush_c), .hold(bus.stall), .bubble(1'b0),
    .prev(f_in), .stage_code(f_code(bus.adel_f)), .q(d_q)
  );

  exc_slot u_slot_e (
    .clk(clk), .reset(reset), .flush(flush_c), .hold(1'b0), .bubble(bus.stall),
    .prev(d_q), .stage_code(d_code(bus.ri_d, bus.syscall_d)), .q(e_q)
  );

  exc_slot u_slot_m (
    .clk(clk), .reset(reset), .flush(flush_c), .hold(1'b0), .bubble(1'b0),
    .prev(e_q), .stage_code(e_code(bus.ov_e, bus.ovl_e, bus.ovs_e)), .q(m_q)
  );

  always_comb code_m = (m_q.code != EXC_NONE) ? m_q.code : m_code(bus.adel_m, bus.ades_m);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_n;
  end

  // Next state plus zero-latency control; req always beats eret, and reset masks both.
  always_comb begin
    state_n    = state;
    flush_c    = 1'b0;
    kill_c     = 1'b0;
    redir_c    = 1'b0;
    exl_clr_c  = 1'b0;
    redir_pc_c = 32'h0;
    if (!reset) begin
      if (bus.req) begin
        flush_c    = 1'b1;
        kill_c     = 1'b1;
        redir_c    = 1'b1;
        redir_pc_c = HANDLER_PC;
        state_n    = ST_HANDLER;
      end else if (bus.eret_m) begin
        flush_c    = 1'b1;
        redir_c    = 1'b1;
        exl_clr_c  = 1'b1;
        redir_pc_c = bus.epc;
        state_n    = ST_RUN;
      end
    end
  end

  // Saturating entry counters; a zero cause at M means the entry was an interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_cnt <= '0;
      int_cnt <= '0;
    end else if (bus.req) begin
      if (exc_cnt != '1) exc_cnt <= exc_cnt + CNT_W'(1);
      if (code_m == EXC_NONE && int_cnt != '1) int_cnt <= int_cnt + CNT_W'(1);
    end
  end

  assign bus.exc_code_m  = 5'(code_m);
  assign bus.bd_m        = m_q.bd;
  assign bus.vpc_m       = m_q.pc;
  assign bus.exl_clr     = exl_clr_c;
  assign bus.flush       = flush_c;
  assign bus.kill_m      = kill_c;
  assign bus.redirect    = redir_c;
  assign bus.redirect_pc = redir_pc_c;
  assign bus.exc_cnt     = exc_cnt;
  assign bus.int_cnt     = int_cnt;
  assign bus.in_handler  = (state == ST_HANDLER);

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception sequencer for the five-stage MIPS pipeline. It collects exception conditions from F, D, E and M, carries one prioritised exception code per in-flight instruction, and presents code, BD flag and victim PC to CP0 at M. It acts on CP0's `Req` and on `eret` by flushing the pipeline, redirecting fetch, killing M-stage side effects and pulsing `EXLClr`. It sits between the hazard unit, the stage registers and CP0.

## Interface
- Parameter `HANDLER_PC`, default 32'h0000_4180: fetch target on exception entry.
- Parameter `CNT_W`, default 16: width of the statistics counters.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `pc_f`  in  32  PC of the F instruction.
- `bd_f`  in  1  F instruction is in a delay slot.
- `adel_f`  in  1  fetch misaligned or out of range.
- `ri_d`, `syscall_d`  in  1 each  D-stage reserved instruction / syscall.
- `ov_e`  in  1  arithmetic overflow.
- `ovl_e`, `ovs_e`  in  1 each  load / store address-add overflow.
- `adel_m`, `ades_m`  in  1 each  M-stage load / store address fault.
- `eret_m`  in  1  `eret` in M.
- `stall`  in  1  hazard stall: F and D hold, E takes a bubble.
- `req`  in  1  CP0 `Req`.
- `epc`  in  32  CP0 `EPCOut`.
- `exc_code_m`  out  5  to CP0 `ExcCodeIn`.
- `bd_m`  out  1  to CP0 `BDIn`.
- `vpc_m`  out  32  to CP0 `VPC`.
- `exl_clr`  out  1  to CP0 `EXLClr`.
- `flush`  out  1  clear the F/D, D/E and E/M stage registers at the next edge.
- `kill_m`  out  1  suppress the M store and the W register write.
- `redirect`  out  1  override next PC.
- `redirect_pc`  out  32  next PC when `redirect` is high.
- `exc_cnt`, `int_cnt`  out  `CNT_W` each  entries taken, and how many were interrupts.
- `in_handler`  out  1  FSM is in HANDLER.

## Operation
- Codes: Int 0, AdEL 4, AdES 5, Syscall 8, RI 10, Ov 12. Code 0 on a stage slot means "none".
- Per-stage slot registers D, E and M each hold {code[4:0], bd, pc[31:0]}.
- Stage priority: the earliest-detected fault wins. A slot that already holds a nonzero code ignores later-stage inputs.
- Within-stage priority:
  - F: `adel_f`.
  - D: RI over Syscall.
  - E: Ov over AdEL (`ovl_e`) over AdES (`ovs_e`).
  - M: AdEL over AdES.
- `exc_code_m` is the M slot code, or the M-stage code if the slot is 0. `bd_m` and `vpc_m` are the M slot's bd and pc.
- Stall: the D slot holds. The E slot loads a bubble with code 0 and the pc and bd of the stalled D instruction. A bubble reaching M therefore still gives CP0 a correct victim PC for an interrupt.
- `req`:
  - `flush`, `kill_m` and `redirect` go high, with `redirect_pc` = `HANDLER_PC`.
  - All slots clear at the edge.
  - `exc_cnt` increments. `int_cnt` also increments when `exc_code_m` is 0.
  - Counters saturate at all-ones.
- `eret_m` with `req` low:
  - `flush`, `redirect` and `exl_clr` go high, with `redirect_pc` = `epc`.
  - `kill_m` stays low.
- `req` and `eret_m` in the same cycle: `req` wins, `exl_clr` stays low, and the target is `HANDLER_PC`.
- `flush` overrides `stall`.
- FSM states and transitions:
  - RUN to HANDLER on `req`.
  - HANDLER to RUN on `eret_m` with `req` low.
  - HANDLER stays in HANDLER on `req`, which is a nested fault; `exc_cnt` still counts it.
  - `eret_m` in RUN redirects and pulses `exl_clr`, and the state stays RUN.

## Timing
- Reset values: all slots 0, FSM RUN, counters 0, all outputs 0 except `vpc_m` = 0.
- `flush`, `kill_m`, `redirect`, `redirect_pc` and `exl_clr` are combinational from the current-cycle `req` and `eret_m`. There is zero added latency.
- Slot, counter and FSM updates take effect at the next `posedge clk`.
- A fault raised at F in cycle t reaches M in cycle t+3 when there is no stall, and CP0 samples it at the end of t+3.
- Asserting `reset` mid-exception discards everything in flight. There is no redirect in the reset cycle.

## Structure
- A shared package holds the `exc_code_t` enum (the six codes), the `slot_t` struct {code, bd, pc} and `HANDLER_PC_DEF`.
- One sub-module is natural: `exc_slot`, one stage slot register with merge-priority and bubble logic, instantiated three times (D, E, M).

## Test plan
- `adel_f` at pc 0x3004, no stalls → `exc_code_m` = 4 and `vpc_m` = 0x3004 three cycles later; `req` high → `redirect_pc` = 0x4180, `exc_cnt` = 1.
- Overflow in a delay slot (`bd_f` = 1, pc 0x3010) → `bd_m` = 1, `exc_code_m` = 12.
- RI in D and Ov in E on the same instruction → code stays 10.
- Stall for 2 cycles, then `req` with the M bubble → `vpc_m` = pc of the stalled D instruction; `int_cnt` = 1; `kill_m` high.
- `eret_m` with `epc` = 0x3020 in HANDLER → `redirect_pc` = 0x3020, `exl_clr` pulse, FSM → RUN.
- `req` and `eret_m` together → target 0x4180, no `exl_clr`.
- `reset` mid-flush → slots 0, counters 0, FSM RUN.
